// File: rtl/acc_share_pkg.sv
// acc_share_pkg: shared types and helpers for the accumulator-sharing arbiter.
//   state_t      : arbiter FSM states
//   ACC_HOLD_MIN : smallest legal value hold time (cycles) for the accumulator pipe
//   idx_w()      : index width for a requester count, never less than 1 bit
package acc_share_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam int ACC_HOLD_MIN = 3;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/acc_share_arbiter_if.sv
// acc_share_arbiter_if: requester/accumulator bundle around the arbiter.
//   req, req_value        : requester levels and packed values (value i at [i*DATA_W +: DATA_W])
//   ack                   : one-hot "value added" pulse back to requesters
//   acc_enable, acc_value : drive the shared 3-stage accumulator
//   busy, grant_id        : status
//   grant_total, overlap_seen : only when ACC_SHARE_STATS_EN is defined
// Modports: master = requester/accumulator side, slave = arbiter.
interface acc_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  import acc_share_pkg::*;

  localparam int IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_value;
  logic [NUM_REQ-1:0]        ack;
  logic                      acc_enable;
  logic [DATA_W-1:0]         acc_value;
  logic                      busy;
  logic [IDX_W-1:0]          grant_id;
`ifdef ACC_SHARE_STATS_EN
  logic [15:0]               grant_total;
  logic                      overlap_seen;

  modport master (output req, req_value,
                  input  ack, acc_enable, acc_value, busy, grant_id, grant_total, overlap_seen);
  modport slave  (input  req, req_value,
                  output ack, acc_enable, acc_value, busy, grant_id, grant_total, overlap_seen);
`else
  modport master (output req, req_value,
                  input  ack, acc_enable, acc_value, busy, grant_id);
  modport slave  (input  req, req_value,
                  output ack, acc_enable, acc_value, busy, grant_id);
`endif

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    : request levels
//   rr_ptr : highest-priority index this round
//   valid  : any request present
//   winner : first set request at or after rr_ptr, wrapping past NUM_REQ-1
module rr_pick
  import acc_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest hit to rr_ptr is the last write.
  always_comb begin
    valid  = |req;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/acc_share_arbiter.sv
// acc_share_arbiter: shares one accumulator datapath among NUM_REQ requesters.
// Round-robin grant, one-cycle acc_enable pulse, acc_value held through the
// accumulator pipeline, then a one-hot ack to the winner.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : acc_share_arbiter_if.slave (req/req_value in; ack, acc_enable,
//              acc_value, busy, grant_id out)
// Optional ACC_SHARE_STATS_EN: adds grant_total (16-bit wrapping grant count)
// and overlap_seen (sticky, >=2 requests seen in an arbitration cycle).
//
// state | meaning
// IDLE  | arbitrate; capture winner id and value
// ISSUE | acc_enable high for this cycle only
// WAIT  | value held while the accumulator pipe consumes it (HOLD_CYCLES cycles)
// ACK   | ack pulse to winner, advance round-robin pointer
module acc_share_arbiter
  import acc_share_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 3
) (
  input logic            clk,
  input logic            rst,
  acc_share_arbiter_if.slave bus
);

  localparam int IDX_W    = idx_w(NUM_REQ);
  // Hold time below the pipeline depth would corrupt the sum, so clamp it.
  localparam int HOLD_EFF = (HOLD_CYCLES < ACC_HOLD_MIN) ? ACC_HOLD_MIN : HOLD_CYCLES;
  localparam int CNT_W    = $clog2(HOLD_EFF);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  grant_id_q, grant_id_d;
  logic [DATA_W-1:0] acc_value_q, acc_value_d;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_winner;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    acc_value_d = acc_value_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_winner;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_winner == IDX_W'(i)) acc_value_d = bus.req_value[i*DATA_W +: DATA_W];
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Counts HOLD_EFF-1 down to 0 inclusive, giving HOLD_EFF cycles in WAIT.
        cnt_d   = CNT_W'(HOLD_EFF - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ACK: begin
        rr_ptr_d = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      acc_value_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      acc_value_q <= acc_value_d;
    end
  end

  // Decoded straight from the state flop so an async reset clears them at once.
  assign bus.acc_enable = (state_q == ISSUE);
  assign bus.ack        = (state_q == ACK) ? (NUM_REQ'(1) << grant_id_q) : '0;
  assign bus.busy       = (state_q != IDLE);
  assign bus.grant_id   = grant_id_q;
  assign bus.acc_value  = acc_value_q;

`ifdef ACC_SHARE_STATS_EN
  logic [15:0] grant_total_q, grant_total_d;
  logic        overlap_q, overlap_d;

  always_comb begin
    grant_total_d = grant_total_q;
    overlap_d     = overlap_q;
    if (state_q == ACK) grant_total_d = grant_total_q + 16'd1;
    if ((state_q == IDLE) && ($countones(bus.req) >= 2)) overlap_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_total_q <= '0;
      overlap_q     <= 1'b0;
    end else begin
      grant_total_q <= grant_total_d;
      overlap_q     <= overlap_d;
    end
  end

  assign bus.grant_total  = grant_total_q;
  assign bus.overlap_seen = overlap_q;
`endif

endmodule

// File: tb/tb_acc_share_arbiter.sv
// tb_acc_share_arbiter: directed scenarios plus randomized requesters, checked
// every cycle against a transaction-level timing model of the arbiter.
module tb_acc_share_arbiter;
  import acc_share_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int H = 3;
  localparam int ACK_PHASE = H + 2;  // cycles from grant sample to ack

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acc_share_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  acc_share_arbiter #(.NUM_REQ(N), .DATA_W(W), .HOLD_CYCLES(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: phase 0 = free, k>0 = k cycles since the grant was taken.
  int          m_phase;
  int          m_gid;
  logic [W-1:0] m_val;
  int          m_rr;
  logic [31:0] m_sum;
  logic [31:0] tb_sum;
  logic [15:0] m_total;
  bit          m_overlap;

  logic [N-1:0] reqs;
  logic [W-1:0] vals [N];
  bit           granted [N];
  logic [N-1:0] obs_ack;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0; m_gid = 0; m_val = '0; m_rr = 0;
    m_total = '0; m_overlap = 0;
    reqs = '0;
    for (int i = 0; i < N; i++) begin
      vals[i] = '0;
      granted[i] = 0;
    end
  endtask

  task automatic apply_inputs();
    bus.req       = reqs;
    bus.req_value = {vals[3], vals[2], vals[1], vals[0]};
  endtask

  function automatic int ack_idx(input logic [N-1:0] a);
    int r = -1;
    for (int i = 0; i < N; i++) if (a[i]) r = i;
    return r;
  endfunction

  task automatic check_outputs();
    logic [N-1:0] exp_ack;
    exp_ack = (m_phase == ACK_PHASE) ? (N'(1) << m_gid) : '0;
    chk("acc_enable", bus.acc_enable, (m_phase == 1));
    chk("ack", bus.ack, exp_ack);
    chk("busy", bus.busy, (m_phase != 0));
    chk("grant_id", bus.grant_id, m_gid);
    chk("acc_value", bus.acc_value, m_val);
`ifdef ACC_SHARE_STATS_EN
    chk("grant_total", bus.grant_total, m_total);
    chk("overlap_seen", bus.overlap_seen, m_overlap);
`endif
    obs_ack = bus.ack;
    if (bus.acc_enable) tb_sum = tb_sum + bus.acc_value;
  endtask

  // What the arbiter does at the coming rising edge, given the inputs now driven.
  task automatic model_edge();
    if (m_phase == 0) begin
      if (reqs != '0) begin
        int w = -1;
        if ($countones(reqs) >= 2) m_overlap = 1;
        for (int k = 0; k < N; k++) begin
          int j = (m_rr + k) % N;
          if (w < 0 && reqs[j]) w = j;
        end
        m_gid = w;
        m_val = vals[w];
        m_sum = m_sum + vals[w];
        granted[w] = 1;
        m_phase = 1;
      end
    end else if (m_phase == ACK_PHASE) begin
      m_rr = (m_gid + 1) % N;
      m_total = m_total + 16'd1;
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic requesters_directed();
    if (m_phase == ACK_PHASE) begin
      reqs[m_gid] = 1'b0;
      granted[m_gid] = 0;
    end
  endtask

  task automatic requesters_random();
    for (int i = 0; i < N; i++) begin
      if (m_phase == ACK_PHASE && m_gid == i) begin
        granted[i] = 0;
        if ($urandom_range(0, 1) == 0) begin
          reqs[i] = 1'b1;
          vals[i] = $urandom;
        end else begin
          reqs[i] = 1'b0;
        end
      end else if (reqs[i] && granted[i] && $urandom_range(0, 5) == 0) begin
        reqs[i] = 1'b0;
        vals[i] = $urandom;
      end else if (!reqs[i] && !granted[i] && $urandom_range(0, 3) == 0) begin
        reqs[i] = 1'b1;
        vals[i] = $urandom;
      end
    end
  endtask

  task automatic step(input bit rnd);
    @(negedge clk);
    check_outputs();
    if (rnd) requesters_random();
    else     requesters_directed();
    apply_inputs();
    model_edge();
  endtask

  initial begin
    int t1_at;
    int ack_steps[$];
    int ack_ids[$];
    logic [31:0] s0;

    rst = 1'b1;
    m_sum = '0;
    tb_sum = '0;
    model_reset();
    apply_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Single requester: latency from sampling to ack, value held throughout.
    reqs[1] = 1'b1;
    vals[1] = 32'h10;
    s0 = tb_sum;
    t1_at = -1;
    for (int k = 0; k < 12; k++) begin
      step(0);
      if (obs_ack != '0 && t1_at < 0) t1_at = k;
    end
    chk("t1_latency", t1_at, 5);
    chk("t1_sum", tb_sum - s0, 32'h10);

    // All four requesting at once: every requester served, acks 6 cycles apart.
    reqs = 4'b1111;
    vals[0] = 1; vals[1] = 2; vals[2] = 3; vals[3] = 4;
    s0 = tb_sum;
    for (int k = 0; k < 30; k++) begin
      step(0);
      if (obs_ack != '0) begin
        ack_steps.push_back(k);
        ack_ids.push_back(ack_idx(obs_ack));
      end
    end
    chk("t2_ack_count", ack_steps.size(), 4);
    for (int i = 1; i < ack_steps.size(); i++) chk("t2_ack_gap", ack_steps[i] - ack_steps[i-1], 6);
    chk("t2_sum", tb_sum - s0, 10);

    // Pointer wrap: pointer sits at 2, requests at 0 and 1; 3 arrives mid-WAIT.
    ack_ids.delete();
    reqs = 4'b0011;
    vals[0] = 32'h100; vals[1] = 32'h200; vals[3] = 32'h400;
    for (int k = 0; k < 30; k++) begin
      step(0);
      if (obs_ack != '0) ack_ids.push_back(ack_idx(obs_ack));
      if (m_phase == 3 && m_gid == 0 && !reqs[3] && !granted[3]) reqs[3] = 1'b1;
    end
    chk("t3_ack_count", ack_ids.size(), 3);
    if (ack_ids.size() == 3) begin
      chk("t3_order0", ack_ids[0], 0);
      chk("t3_order1", ack_ids[1], 1);
      chk("t3_order2", ack_ids[2], 3);
    end

    // Reset in WAIT: outputs clear at once and no ack follows.
    reqs[2] = 1'b1;
    vals[2] = 32'h77;
    for (int k = 0; k < 10 && m_phase != 3; k++) step(0);
    chk("t4_in_wait", m_phase, 3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_enable", bus.acc_enable, 0);
    chk("t4_rst_ack", bus.ack, 0);
    chk("t4_rst_busy", bus.busy, 0);
    chk("t4_rst_grant", bus.grant_id, 0);
    chk("t4_rst_value", bus.acc_value, 0);
    model_reset();
    apply_inputs();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) step(0);

    // Requester drops and changes its value after the grant: original value added.
    reqs[2] = 1'b1;
    vals[2] = 32'hAB;
    s0 = tb_sum;
    step(0);
    reqs[2] = 1'b0;
    vals[2] = 32'h5555;
    t1_at = -1;
    for (int k = 0; k < 10; k++) begin
      step(0);
      if (obs_ack == 4'b0100 && t1_at < 0) t1_at = k;
    end
    chk("t5_ack_seen", (t1_at >= 0), 1);
    chk("t5_sum", tb_sum - s0, 32'hAB);

    // Randomized requesters.
    for (int k = 0; k < 3000; k++) step(1);
    for (int k = 0; k < 40; k++) step(0);
    chk("total_sum", tb_sum, m_sum);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
